// File: rtl/load_store_unit.sv
// Load/store bridge between the core's LS stage and a word-addressed RAM.
// Checks alignment/range, turns sub-word stores into read-modify-write, extends load data.
module load_store_unit #(
    parameter int unsigned DEPTH_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_read_enable,
    output logic        mem_write_enable,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t      state_q, state_d;
    logic        r_write, r_signed;
    logic [1:0]  r_size;
    logic [31:0] r_addr, r_wdata;
    logic [31:0] word_q, rdata_q;
    logic        error_q;

    logic        req_bad;
    logic [4:0]  lane_shift;
    logic [31:0] shifted, load_value, lane_mask, lane_data, merged_word;

    always_comb begin
        req_bad = 1'b0;
        if (req_size == 2'b11)                              req_bad = 1'b1;
        if (req_size == 2'b01 && req_addr[0])               req_bad = 1'b1;
        if (req_size == 2'b10 && req_addr[1:0] != 2'b00)    req_bad = 1'b1;
        if ({2'b00, req_addr[31:2]} >= 32'(DEPTH_WORDS))    req_bad = 1'b1;
    end

    // Lane position comes from the registered byte offset; halfwords are aligned so addr[0]=0.
    assign lane_shift = {r_addr[1:0], 3'b000};
    assign shifted    = mem_rdata >> lane_shift;

    always_comb begin
        load_value = mem_rdata;
        case (r_size)
            2'b00:   load_value = {{24{r_signed & shifted[7]}},  shifted[7:0]};
            2'b01:   load_value = {{16{r_signed & shifted[15]}}, shifted[15:0]};
            default: load_value = mem_rdata;
        endcase
    end

    always_comb begin
        lane_mask = (r_size == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF;
        lane_data = r_wdata & lane_mask;
        merged_word = (word_q & ~(lane_mask << lane_shift)) | (lane_data << lane_shift);
    end

    assign mem_addr  = {2'b00, r_addr[31:2]};
    assign mem_wdata = (r_size == 2'b10) ? r_wdata : merged_word;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            r_write  <= 1'b0;
            r_signed <= 1'b0;
            r_size   <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            word_q   <= '0;
            rdata_q  <= '0;
            error_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        r_write  <= req_write;
                        r_signed <= req_signed;
                        r_size   <= req_size;
                        r_addr   <= req_addr;
                        r_wdata  <= req_wdata;
                        rdata_q  <= '0;
                        error_q  <= req_bad;
                    end
                end
                READ: begin
                    word_q <= mem_rdata;
                    if (!r_write) rdata_q <= load_value;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d          = state_q;
        req_ready        = 1'b0;
        resp_valid       = 1'b0;
        mem_read_enable  = 1'b0;
        mem_write_enable = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_bad)                             state_d = RESP;
                    else if (req_write && req_size == 2'b10) state_d = WRITE;
                    else                                     state_d = READ;
                end
            end
            READ: begin
                mem_read_enable = 1'b1;
                state_d = r_write ? WRITE : RESP;
            end
            WRITE: begin
                mem_write_enable = 1'b1;
                state_d = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign resp_rdata = rdata_q;
    assign resp_error = error_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized + directed bench for load_store_unit against a byte-level memory model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_write, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_error;
    logic [31:0] resp_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_read_enable, mem_write_enable;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    logic [31:0] ram [0:1023];
    logic [7:0]  ref_mem [0:4095];

    always #5 clk = ~clk;

    load_store_unit #(.DEPTH_WORDS(1024)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_error(resp_error), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_read_enable(mem_read_enable),
        .mem_write_enable(mem_write_enable), .mem_rdata(mem_rdata)
    );

    // Downstream RAM: combinational read, write on rising edge.
    assign mem_rdata = (mem_addr < 32'd1024) ? ram[mem_addr[9:0]] : 32'h0;
    always @(posedge clk) if (mem_write_enable) ram[mem_addr[9:0]] <= mem_wdata;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic is_err(input logic [1:0] sz, input logic [31:0] a);
        return (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00)
               || (a >= 32'h1000);
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] sz, input logic sg, input logic [31:0] a);
        logic [7:0]  b;
        logic [15:0] h;
        b = ref_mem[a[11:0]];
        h = {ref_mem[a[11:0] + 12'd1], b};
        if (sz == 2'b00) return sg ? 32'(signed'(b)) : 32'(b);
        if (sz == 2'b01) return sg ? 32'(signed'(h)) : 32'(h);
        return {ref_mem[a[11:0] + 12'd3], ref_mem[a[11:0] + 12'd2], h};
    endfunction

    task automatic model_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        int unsigned n;
        n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        for (int unsigned i = 0; i < n; i++) ref_mem[a[11:0] + 12'(i)] = d[8*i +: 8];
    endtask

    task automatic run_req(input logic w, input logic [1:0] sz, input logic sg,
                           input logic [31:0] a, input logic [31:0] wd,
                           input int unsigned hold, input logic early);
        logic        err, saw_rd, saw_wr, both;
        logic [31:0] exp_rdata, held;
        int unsigned lat, exp_lat;
        err = is_err(sz, a);
        exp_rdata = (err || w) ? 32'h0 : model_load(sz, sg, a);
        exp_lat = err ? 1 : (!w || sz == 2'b10) ? 2 : 3;

        @(negedge clk);
        check("req_ready_idle", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = wd; resp_ready = early;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1; saw_rd = 0; saw_wr = 0; both = 0;
        while (!resp_valid && lat < 8) begin
            if (mem_read_enable) saw_rd = 1;
            if (mem_write_enable) saw_wr = 1;
            if (mem_read_enable && mem_write_enable) both = 1;
            if (mem_read_enable || mem_write_enable) check("mem_addr", mem_addr, a >> 2);
            @(posedge clk); #1;
            lat++;
        end
        if (!err && w) model_store(sz, a, wd);
        check("latency", lat, exp_lat);
        check("resp_error", {31'b0, resp_error}, {31'b0, err});
        check("resp_rdata", resp_rdata, exp_rdata);
        check("read_strobe", {31'b0, saw_rd}, {31'b0, !err && !(w && sz == 2'b10)});
        check("write_strobe", {31'b0, saw_wr}, {31'b0, !err && w});
        check("enable_excl", {31'b0, both}, 32'd0);

        held = resp_rdata;
        for (int unsigned i = 0; i < hold; i++) begin
            @(negedge clk);
            resp_ready = 1'b0;
            req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_addr = 32'h0;
            @(posedge clk); #1;
            check("hold_valid", {31'b0, resp_valid}, 32'd1);
            check("hold_rdata", resp_rdata, held);
            check("hold_ready", {31'b0, req_ready}, 32'd0);
        end
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        check("post_hs_ready", {31'b0, req_ready}, 32'd1);
        check("post_hs_valid", {31'b0, resp_valid}, 32'd0);
        @(negedge clk);
        resp_ready = 1'b0;
        req_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        int unsigned pick, wr_seen;
        for (int i = 0; i < 1024; i++) ram[i] = 32'h0;
        for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h0;
        reset = 1'b1; req_valid = 0; req_write = 0; req_size = 0; req_signed = 0;
        req_addr = 0; req_wdata = 0; resp_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", {31'b0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_resp_error", {31'b0, resp_error}, 32'd0);
        check("rst_enables", {30'b0, mem_read_enable, mem_write_enable}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        run_req(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 0, 0);
        run_req(0, 2'b10, 0, 32'h10, 32'h0, 0, 0);
        run_req(1, 2'b10, 0, 32'h20, 32'h11223344, 0, 0);
        run_req(1, 2'b00, 0, 32'h21, 32'h000000AA, 0, 0);
        run_req(0, 2'b10, 0, 32'h20, 32'h0, 0, 0);
        run_req(0, 2'b00, 1, 32'h21, 32'h0, 0, 0);
        run_req(0, 2'b00, 0, 32'h21, 32'h0, 0, 1);
        run_req(1, 2'b10, 0, 32'h30, 32'h80007FFF, 0, 0);
        run_req(0, 2'b01, 1, 32'h32, 32'h0, 0, 0);
        run_req(0, 2'b01, 1, 32'h30, 32'h0, 0, 0);
        run_req(1, 2'b01, 0, 32'h36, 32'hCAFE1234, 0, 0);
        run_req(0, 2'b10, 0, 32'h34, 32'h0, 0, 0);
        run_req(0, 2'b01, 0, 32'h41, 32'h0, 0, 0);
        run_req(1, 2'b10, 0, 32'h42, 32'h12345678, 0, 0);
        run_req(0, 2'b11, 0, 32'h40, 32'h0, 0, 0);
        run_req(0, 2'b10, 0, 32'h1000, 32'h0, 0, 0);
        run_req(1, 2'b10, 0, 32'h0FFC, 32'hA5A5_5A5A, 0, 0);
        run_req(0, 2'b10, 0, 32'h0FFC, 32'h0, 0, 0);
        run_req(0, 2'b10, 0, 32'h8000_0010, 32'h0, 0, 0);
        run_req(0, 2'b10, 1, 32'h10, 32'h0, 5, 0);

        for (int unsigned n = 0; n < 60; n++) begin
            pick = $urandom_range(0, 9);
            if (pick == 0)      a = 32'h0FFC | 32'($urandom_range(0, 3));
            else if (pick == 1) a = 32'h1000 + 32'($urandom_range(0, 7));
            else if (pick == 2) a = $urandom;
            else                a = 32'($urandom_range(0, 127));
            run_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    a, $urandom, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        // Reset during READ of a sub-word store must abandon it without any write.
        run_req(1, 2'b10, 0, 32'h50, 32'h11223344, 0, 0);
        @(negedge clk);
        req_valid = 1; req_write = 1; req_size = 2'b00; req_addr = 32'h51; req_wdata = 32'h77;
        @(posedge clk); #1;
        req_valid = 0;
        check("rst_mid_in_read", {31'b0, mem_read_enable}, 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rst_mid_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_mid_ready", {31'b0, req_ready}, 32'd1);
        check("rst_mid_addr", mem_addr, 32'h0);
        wr_seen = 0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (mem_write_enable) wr_seen++;
            @(posedge clk); #1;
        end
        check("rst_mid_no_write", wr_seen, 32'd0);
        run_req(0, 2'b10, 0, 32'h50, 32'h0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Bridges the core's load/store pipeline stage to the word-addressed data RAM directly downstream. Accepts one byte-addressed request per transaction over a valid/ready handshake and checks alignment and range. Sub-word stores become read-modify-write sequences on the RAM. Load data is returned byte/halfword/word aligned and zero- or sign-extended.

## Interface
- DEPTH_WORDS, 1024, number of 32-bit words in the downstream RAM
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept; high only in IDLE
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- req_signed  in  1  loads only: 1 sign-extend, 0 zero-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- resp_valid  out  1  response present
- resp_ready  in  1  consumer accepts response
- resp_rdata  out  32  load result, extended; 0 for stores and errors
- resp_error  out  1  request rejected, no memory access performed
- mem_addr  out  32  word index to RAM = {2'b00, addr[31:2]}
- mem_wdata  out  32  word written to RAM
- mem_read_enable  out  1  RAM read strobe
- mem_write_enable  out  1  RAM write strobe
- mem_rdata  in  32  RAM read data, combinational from mem_addr

## Operation
- FSM states: IDLE, READ, WRITE, RESP.
- IDLE: req_ready=1. On req_valid, register write, size, signed, addr, and wdata, then check the request.
  - Error: size==11, half with addr[0]=1, word with addr[1:0]!=0, or addr[31:2] >= DEPTH_WORDS. Go to RESP with resp_error=1 and resp_rdata=0.
  - Load, or sub-word store: go to READ.
  - Word store: go to WRITE.
- READ: mem_read_enable=1. Capture mem_rdata into an internal word register at the cycle end.
  - Load: extract the lane, extend it into resp_rdata, go to RESP.
  - Sub-word store: go to WRITE.
- WRITE: mem_write_enable=1.
  - mem_wdata is req_wdata for a word store.
  - For a sub-word store, mem_wdata is the captured word with the target lane replaced. Byte k=addr[1:0] occupies [8k+7:8k]. Halfword h=addr[1] occupies [16h+15:16h]. Little-endian.
  - Go to RESP.
- RESP: resp_valid=1, held with resp_rdata and resp_error stable until resp_ready. On resp_valid && resp_ready, go to IDLE.
- mem_addr and mem_wdata are held from registered fields. The enables are 0 outside READ/WRITE, and both enables are never high together.
- Extension: a signed byte load replicates bit 7 into [31:8], and a signed halfword load replicates bit 15 into [31:16]. An unsigned load zero-fills. A word load ignores req_signed.

## Timing
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_error=0, mem_read_enable=0, mem_write_enable=0, mem_addr=0, mem_wdata=0.
- Request accepted at edge T:
  - Error: resp_valid at T+1.
  - Load: READ at T+1, resp_valid at T+2.
  - Word store: WRITE at T+1, RAM updated at edge T+2, resp_valid at T+2.
  - Sub-word store: READ at T+1, WRITE at T+2, resp_valid at T+3.
- Minimum occupancy: a response handshake at edge R gives req_ready=1 in cycle R+1. Peak throughput is one load per 3 cycles.
- No request is accepted while not in IDLE. req_valid outside IDLE is ignored and must be held by the source.
- resp_ready asserted early (before RESP) has no effect.
- Reset mid-operation: the transaction is abandoned with no response, and all outputs take their reset values next cycle.
  - A write whose strobe is high in the cycle reset is sampled still lands at that edge.
  - No further write is issued after reset.
- Boundaries:
  - addr 0x0FFC with DEPTH_WORDS=1024 is legal.
  - addr 0x1000 is an error.
  - High address bits set beyond depth are an error; there is no wrap-around.

## Test plan
- Word store 0xDEADBEEF to 0x10, then word load 0x10: store response at T+2 with error=0 and rdata=0. Load returns 0xDEADBEEF at T+2. mem_addr=4 during access.
- Word 0x11223344 at 0x20. Byte store 0xAA to 0x21: word becomes 0x1122AA44 and response arrives at T+3. Signed byte load 0x21 returns 0xFFFFFFAA. Unsigned byte load returns 0x000000AA.
- Word 0x8000_7FFF at 0x30. Signed half load 0x32 returns 0xFFFF8000. Signed half load 0x30 returns 0x00007FFF.
- Half load 0x41, word store 0x42, size=11, and word load 0x1000: each gives resp_error=1 and rdata=0 at T+1. mem_read_enable and mem_write_enable stay 0 throughout.
- Load response with resp_ready low for 5 cycles: resp_valid and resp_rdata hold, req_ready stays 0, and a new req_valid is not accepted until the cycle after the handshake.
- Reset asserted in READ of a sub-word store: no write strobe is ever issued, resp_valid=0, and state is IDLE next cycle. The RAM word is unchanged.
